// File: rtl/rr_stream_arbiter_pkg.sv
// Shared definitions for the round-robin packet stream arbiter:
// default geometry, FSM state encoding and a modular index helper.
package rr_stream_arbiter_pkg;

  localparam int L_DEFAULT = 8;
  localparam int N_DEFAULT = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // (base + offset) mod n, used for the rotating priority search.
  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/rr_stream_arbiter_if.sv
// Bundle of requester-side and downstream-side stream signals.
// master = traffic source/sink environment, slave = the arbiter.
interface rr_stream_arbiter_if
  import rr_stream_arbiter_pkg::*;
#(
  parameter int L  = L_DEFAULT,
  parameter int N  = N_DEFAULT,
  parameter int IW = $clog2(N)
) ();

  logic [N-1:0]   valid_in;
  logic [N-1:0]   ready_in;
  logic [N*L-1:0] data_in;
  logic [N-1:0]   last_in;
  logic           valid_out;
  logic           ready_out;
  logic [L-1:0]   data_out;
  logic           last_out;
  logic [IW-1:0]  grant_id;
  logic           busy;

  modport master (
    output valid_in, data_in, last_in, ready_out,
    input  ready_in, valid_out, data_out, last_out, grant_id, busy
  );

  modport slave (
    input  valid_in, data_in, last_in, ready_out,
    output ready_in, valid_out, data_out, last_out, grant_id, busy
  );

endinterface

// File: rtl/rr_stream_arbiter_skid.sv
// Two-entry skid buffer with a registered input ready. The output
// register feeds downstream directly; the skid register catches the one
// extra beat that can arrive in the cycle downstream stalls.
module stream_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_reg, out_valid_next;
  logic [W-1:0] out_data_reg,  out_data_next;
  logic         skid_valid_reg, skid_valid_next;
  logic [W-1:0] skid_data_reg,  skid_data_next;
  logic         space_reg, space_next;
  logic         push;
  logic         pop;

  assign push      = in_valid && space_reg;
  assign pop       = out_valid_reg && out_ready;
  assign in_ready  = space_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  // Next-state of the two entries; the skid entry always drains first so order is kept.
  always_comb begin
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (!out_valid_reg || pop) begin
      if (skid_valid_reg) begin
        out_valid_next  = 1'b1;
        out_data_next   = skid_data_reg;
        skid_valid_next = 1'b0;
      end else if (push) begin
        out_valid_next = 1'b1;
        out_data_next  = in_data;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (push) begin
      skid_valid_next = 1'b1;
      skid_data_next  = in_data;
    end
    // Ready is registered: space exists next cycle only if the skid slot is free.
    space_next = !skid_valid_next;
  end

  // Buffer state registers; reset empties the buffer and withholds ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      space_reg      <= 1'b0;
    end else begin
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      space_reg      <= space_next;
    end
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin packet arbiter: N multi-beat streams merged onto one output.
// Arbitration happens only between packets; the winner stays locked until
// its last beat is accepted. Output goes through a two-entry skid buffer.
module rr_stream_arbiter
  import rr_stream_arbiter_pkg::*;
#(
  parameter int L  = L_DEFAULT,
  parameter int N  = N_DEFAULT,
  parameter int IW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_stream_arbiter_if.slave   bus
);

  localparam int BW = L + 1 + IW;

  arb_state_t    state_reg;
  logic [IW-1:0] rr_ptr_reg;
  logic [IW-1:0] grant_reg;
  logic          busy_reg;

  logic [L-1:0]  data_arr [N];
  logic [IW-1:0] search_idx;
  logic [IW-1:0] winner;
  logic          winner_found;
  logic [IW-1:0] sel;
  logic          sel_active;
  logic          sel_last;
  logic          space;
  logic          accept;
  logic [N-1:0]  ready_vec;
  logic [BW-1:0] push_word;
  logic [BW-1:0] out_word;

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] p);
    return IW'(rr_index(int'(p), 1, N));
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign data_arr[gi] = bus.data_in[gi*L +: L];
  end

  // Rotating-priority search: first valid requester at or after rr_ptr.
  always_comb begin
    search_idx   = '0;
    winner       = '0;
    winner_found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      search_idx = IW'(rr_index(int'(rr_ptr_reg), k, N));
      if (bus.valid_in[search_idx]) begin
        winner       = search_idx;
        winner_found = 1'b1;
      end
    end
  end

  assign sel        = (state_reg == LOCKED) ? grant_reg : winner;
  assign sel_active = (state_reg == LOCKED) || winner_found;
  assign sel_last   = bus.last_in[sel];
  assign accept     = sel_active && space && bus.valid_in[sel];
  assign push_word  = {data_arr[sel], sel_last, sel};

  // Only the selected requester sees ready, and only when the buffer has room.
  always_comb begin
    ready_vec = '0;
    if (space && sel_active) begin
      ready_vec[sel] = 1'b1;
    end
  end

  assign bus.ready_in = ready_vec;
  assign bus.busy     = busy_reg;

  // Packet-level FSM: lock on a non-final beat, release and rotate on the last beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
      busy_reg   <= 1'b0;
    end else if (accept) begin
      case (state_reg)
        IDLE: begin
          if (!sel_last) begin
            state_reg <= LOCKED;
            grant_reg <= winner;
            busy_reg  <= 1'b1;
          end else begin
            rr_ptr_reg <= ptr_after(winner);
          end
        end
        LOCKED: begin
          if (sel_last) begin
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
            rr_ptr_reg <= ptr_after(grant_reg);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  stream_skid_buffer #(.W(BW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_ready  (space),
    .in_data   (push_word),
    .out_valid (bus.valid_out),
    .out_ready (bus.ready_out),
    .out_data  (out_word)
  );

  assign {bus.data_out, bus.last_out, bus.grant_id} = out_word;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Randomized bench for rr_stream_arbiter against a packet-level model:
// per-requester packet queues as sources, a FIFO queue for the output
// buffer, and the round-robin / packet-lock rules applied per cycle.
module tb_rr_stream_arbiter;
  import rr_stream_arbiter_pkg::*;

  localparam int L  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic [L-1:0] data;
    logic         last;
  } src_beat_t;

  typedef struct packed {
    logic [L-1:0]  data;
    logic          last;
    logic [IW-1:0] id;
  } out_beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  rr_stream_arbiter_if #(.L(L), .N(N), .IW(IW)) bus ();

  rr_stream_arbiter #(.L(L), .N(N), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  src_beat_t src_q [N][$];
  out_beat_t m_q[$];
  bit        m_locked;
  bit        m_space;
  int        m_ptr;
  int        m_grant;
  int        n_checks = 0;
  int        n_errors = 0;
  int        vprob = 100;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_space  = 1'b0;
    m_ptr    = 0;
    m_grant  = 0;
    m_q.delete();
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) src_q[i].delete();
  endtask

  task automatic add_packet(input int req, input int len);
    src_beat_t b;
    for (int j = 0; j < len; j++) begin
      b.data = L'($urandom);
      b.last = (j == len - 1);
      src_q[req].push_back(b);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_value("ready_before_edge", 32'(bus.ready_in), 32'd0);
    @(posedge clk);
    #1;
    m_space = 1'b1;
  endtask

  // One clock: drive sources, compare DUT against model, advance model.
  task automatic do_cycle(input bit rdy);
    logic [N-1:0] v;
    logic [N-1:0] exp_ready;
    int           sel;
    int           idx;
    bit           acc;
    src_beat_t    b;
    out_beat_t    ob;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && $urandom_range(99) < vprob) begin
        v[i] = 1'b1;
        bus.data_in[i*L +: L] = src_q[i][0].data;
        bus.last_in[i]        = src_q[i][0].last;
      end else begin
        v[i] = 1'b0;
        bus.data_in[i*L +: L] = L'($urandom);
        bus.last_in[i]        = 1'($urandom_range(1));
      end
    end
    bus.valid_in  = v;
    bus.ready_out = rdy;
    #1;
    sel = -1;
    if (m_locked) begin
      sel = m_grant;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (sel < 0 && v[idx]) sel = idx;
      end
    end
    exp_ready = '0;
    acc = 1'b0;
    if (sel >= 0) begin
      if (m_space) exp_ready[sel] = 1'b1;
      acc = m_space && v[sel];
    end
    check_value("ready_in", 32'(bus.ready_in), 32'(exp_ready));
    check_value("valid_out", 32'(bus.valid_out), 32'(m_q.size() > 0));
    check_value("busy", 32'(bus.busy), 32'(m_locked));
    if (m_q.size() > 0) begin
      check_value("data_out", 32'(bus.data_out), 32'(m_q[0].data));
      check_value("last_out", 32'(bus.last_out), 32'(m_q[0].last));
      check_value("grant_id", 32'(bus.grant_id), 32'(m_q[0].id));
      if (rdy) $display("[%0t] beat id=%0d data=%02h last=%0b", $time, m_q[0].id, m_q[0].data, m_q[0].last);
      if (rdy) void'(m_q.pop_front());
    end
    if (acc) begin
      b = src_q[sel].pop_front();
      ob.data = b.data;
      ob.last = b.last;
      ob.id   = IW'(sel);
      m_q.push_back(ob);
      if (!m_locked) begin
        if (!b.last) begin
          m_locked = 1'b1;
          m_grant  = sel;
        end else begin
          m_ptr = (sel + 1) % N;
        end
      end else if (b.last) begin
        m_locked = 1'b0;
        m_ptr    = (m_grant + 1) % N;
      end
    end
    m_space = (m_q.size() < 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    src_beat_t sb;
    bit        reached;
    bus.valid_in  = '0;
    bus.data_in   = '0;
    bus.last_in   = '0;
    bus.ready_out = 1'b0;
    model_reset();
    clear_sources();

    // Reset state
    #12;
    check_value("rst_ready_in", 32'(bus.ready_in), 32'd0);
    check_value("rst_valid_out", 32'(bus.valid_out), 32'd0);
    check_value("rst_data_out", 32'(bus.data_out), 32'd0);
    check_value("rst_last_out", 32'(bus.last_out), 32'd0);
    check_value("rst_grant_id", 32'(bus.grant_id), 32'd0);
    check_value("rst_busy", 32'(bus.busy), 32'd0);
    release_reset();

    // Single beat from requester 0
    vprob = 100;
    sb.data = 8'h5A;
    sb.last = 1'b1;
    src_q[0].push_back(sb);
    repeat (4) do_cycle(1'b1);

    // Fairness: every requester offers single-beat packets continuously
    for (int i = 0; i < N; i++) repeat (6) add_packet(i, 1);
    repeat (30) do_cycle(1'b1);

    // Lock: 3-beat packet on req0 while req1 keeps requesting
    for (int j = 0; j < 3; j++) begin
      sb.data = 8'h10 + 8'(j);
      sb.last = (j == 2);
      src_q[0].push_back(sb);
    end
    add_packet(1, 1);
    add_packet(1, 1);
    repeat (10) do_cycle(1'b1);

    // Backpressure: 8-beat stream on req2 with a 4-cycle downstream stall
    for (int j = 0; j < 8; j++) begin
      sb.data = 8'h01 + 8'(j);
      sb.last = (j == 7);
      src_q[2].push_back(sb);
    end
    for (int c = 0; c < 20; c++) do_cycle(!(c >= 3 && c <= 6));

    // Random traffic with gaps on both sides
    vprob = 70;
    for (int i = 0; i < N; i++) repeat (40) add_packet(i, $urandom_range(1, 4));
    repeat (1200) do_cycle($urandom_range(99) < 60);
    vprob = 100;
    repeat (20) do_cycle(1'b1);
    check_value("drained", 32'(m_q.size()), 32'd0);

    // Reset while locked on req3 with two beats buffered
    clear_sources();
    add_packet(3, 6);
    reached = 1'b0;
    for (int c = 0; c < 40 && !reached; c++) begin
      do_cycle(1'b0);
      reached = m_locked && (m_grant == 3) && (m_q.size() == 2);
    end
    check_value("reach_lock_full", 32'(reached), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_value("mid_rst_ready_in", 32'(bus.ready_in), 32'd0);
    check_value("mid_rst_valid_out", 32'(bus.valid_out), 32'd0);
    check_value("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_value("mid_rst_grant_id", 32'(bus.grant_id), 32'd0);
    model_reset();
    clear_sources();
    bus.valid_in = '0;
    @(negedge clk);
    release_reset();
    add_packet(1, 1);
    add_packet(2, 1);
    repeat (6) do_cycle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_stream_arbiter.md
RR_STREAM_ARBITER -- requirements
Module: rr_stream_arbiter

Interface
REQ-001 Parameter: L, 8, data width per stream.
REQ-002 Parameter: N, 4, number of requesters (2..8).
REQ-003 Parameter: IW, $clog2(N), width of grant index.
REQ-004 Port: clk  input  1  clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-low.
REQ-006 Port: valid_in  input  N  per-requester beat valid.
REQ-007 Port: ready_in  output  N  per-requester beat accepted when valid_in[i]&&ready_in[i].
REQ-008 Port: data_in  input  N*L  requester i data in bits [i*L+L-1 : i*L].
REQ-009 Port: last_in  input  N  marks final beat of requester i packet.
REQ-010 Port: valid_out  output  1  downstream beat valid.
REQ-011 Port: ready_out  input  1  downstream accept; transfer when valid_out&&ready_out.
REQ-012 Port: data_out  output  L  downstream data.
REQ-013 Port: last_out  output  1  downstream end-of-packet.
REQ-014 Port: grant_id  output  IW  source index of current data_out beat.
REQ-015 Port: busy  output  1  high while state is LOCKED.

Function
REQ-016 Packets are multi-beat; arbitration occurs only at packet boundaries; beats of two packets never interleave on the output.
REQ-017 State machine SHALL have two states: IDLE (no packet open) and LOCKED (packet from grant_reg open).
REQ-018 IDLE: winner = first i with valid_in[i]=1 searching from rr_ptr upward modulo N; ready_in[winner]=space, all other ready_in=0; no valid_in -> all ready_in=0.
REQ-019 LOCKED: ready_in[grant_reg]=space, all others 0; valid_in of other requesters ignored.
REQ-020 IDLE accepted beat with last_in=0 -> LOCKED, grant_reg=winner; with last_in=1 -> stay IDLE, rr_ptr=(winner+1) mod N.
REQ-021 LOCKED accepted beat with last_in=1 -> IDLE, rr_ptr=(grant_reg+1) mod N; rr_ptr unchanged otherwise.
REQ-022 Output path is a 2-entry skid buffer holding {data,last,id}; space = skid not full, taken from a register (no combinational ready_out->ready_in path).
REQ-023 Latency: accepted beat appears on valid_out/data_out the next cycle when buffer empty.
REQ-024 Throughput: one beat per cycle sustained while ready_out=1, including back-to-back packets from different requesters (no idle bubble at packet boundary).
REQ-025 ready_out=0: buffer absorbs at most one additional beat, then space=0; data_out/last_out/grant_id stable while valid_out=1 and ready_out=0.
REQ-026 Simultaneous push and pop on a full buffer is not possible (space=0); push and pop in same cycle on 1-entry buffer keeps occupancy 1, order preserved.
REQ-027 Requester dropping valid_in mid-packet while LOCKED: arbiter stays LOCKED, waits; no other requester granted.
REQ-028 busy=1 exactly when state is LOCKED.

Reset
REQ-029 rst=0 asynchronously forces: state IDLE, rr_ptr=0, grant_reg=0, skid buffer empty, valid_out=0, data_out=0, last_out=0, grant_id=0, busy=0, space=0 so ready_in=0.
REQ-030 space SHALL become 1 on first rising clk edge after rst deasserts; reset mid-packet discards the open packet and buffered beats.

Structure
REQ-031 Shared package holds default L, default N, and the IDLE/LOCKED state encoding.
REQ-032 One sub-module: stream_skid_buffer (width L+1+IW, registered ready, 2 entries); arbitration logic and FSM stay in the top module.

Verification
REQ-033 Single beat: N=4, valid_in=0001, last_in=0001, data=0x5A, ready_out=1 -> next cycle valid_out=1, data_out=0x5A, last_out=1, grant_id=0, rr_ptr=1.
REQ-034 Fairness: all four requesters continuously offer 1-beat packets, ready_out=1 -> grant_id sequence 0,1,2,3,0,... with no gap cycles.
REQ-035 Lock: req0 sends 3-beat packet (0x10,0x11,0x12 last), req1 valid throughout -> output 0x10,0x11,0x12 id 0, then req1 beats id 1; busy high during packet until last accepted.
REQ-036 Backpressure: stream of 0x01..0x08 from req2, ready_out low for cycles 3-6 -> ready_in[2] drops one cycle after stall, no beat lost or duplicated, output order 0x01..0x08.
REQ-037 Reset mid-packet: assert rst while LOCKED on req3 with 2 beats buffered -> valid_out=0, busy=0, ready_in=0 immediately; after release, req1 single beat wins with grant_id=1 (rr_ptr=0 search).
